jt6295_timing_gen: RTL and testbench



---
 rtl/jt6295_timing_gen_pkg.sv | 18 +
 rtl/jt6295_timing_gen_div_sel.sv | 30 +++
 rtl/jt6295_timing_gen.sv | 132 +++++++++++++
 tb/tb_jt6295_timing_gen.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jt6295_timing_gen_pkg.sv
// Shared constants and divisor clamp for the JT6295 sample-rate timing generator.
// Optional evenly-spread slot schedule is selected with JT6295_TIMING_SPREAD_EN.
package jt6295_pkg;

    localparam int JT6295_DIV_HI = 132;
    localparam int JT6295_DIV_LO = 165;
    localparam int JT6295_CHW    = 2;
    localparam int JT6295_DW     = 10;

    // The shortest legal period is two cen pulses per voice slot.
    function automatic int unsigned jt6295_clamp_sel(input int unsigned sel,
                                                     input int unsigned chw);
        int unsigned min_div;
        min_div = 32'd2 << chw;
        return (sel < min_div) ? min_div : sel;
    endfunction

endpackage

// File: rtl/jt6295_timing_gen_div_sel.sv
// Combinational divisor select (programmable or ss table) with minimum-period clamp.
module jt6295_div_sel
    import jt6295_pkg::*;
#(
    parameter int CHW    = JT6295_CHW,
    parameter int DW     = JT6295_DW,
    parameter int DIV_HI = JT6295_DIV_HI,
    parameter int DIV_LO = JT6295_DIV_LO
) (
    input  logic          ss,
    input  logic          prog_en,
    input  logic [DW-1:0] prog_div,
    output logic [DW-1:0] sel
);

    logic [DW-1:0] raw;

    always_comb begin
        raw = '0;
        if (prog_en) begin
            raw = prog_div;
        end else if (ss) begin
            raw = DW'(DIV_HI);
        end else begin
            raw = DW'(DIV_LO);
        end
        sel = DW'(jt6295_clamp_sel(32'(raw), CHW));
    end

endmodule

// File: rtl/jt6295_timing_gen.sv
// JT6295 sample-rate timing generator: divides cen, emits sample and voice-slot strobes.
// Define JT6295_TIMING_SPREAD_EN to spread slot strobes evenly across the period.
module jt6295_timing_gen
    import jt6295_pkg::*;
#(
    parameter int CHW    = JT6295_CHW,
    parameter int DW     = JT6295_DW,
    parameter int DIV_HI = JT6295_DIV_HI,
    parameter int DIV_LO = JT6295_DIV_LO
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           ss,
    input  logic           prog_en,
    input  logic [DW-1:0]  prog_div,
    output logic           cen_sr,
    output logic           cen_ch,
    output logic [CHW-1:0] slot,
    output logic [DW-1:0]  div_act
);

    localparam int CH = 1 << CHW;

    logic [DW-1:0]  sel;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  div_act_q, div_act_d;
    logic [CHW-1:0] slot_q, slot_d;
    logic           cen_sr_q, cen_sr_d;
    logic           cen_ch_q, cen_ch_d;
    logic           wrap;

`ifdef JT6295_TIMING_SPREAD_EN
    logic [DW-1:0]  nxt_q, nxt_d;
    logic [CHW-1:0] sidx_q, sidx_d;
    logic           done_q, done_d;
    logic [DW-1:0]  sp;
`endif

    jt6295_div_sel #(
        .CHW    (CHW),
        .DW     (DW),
        .DIV_HI (DIV_HI),
        .DIV_LO (DIV_LO)
    ) u_div_sel (
        .ss       (ss),
        .prog_en  (prog_en),
        .prog_div (prog_div),
        .sel      (sel)
    );

    assign wrap = (cnt_q == div_act_q - DW'(1));

    always_comb begin
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        slot_d    = slot_q;
        cen_sr_d  = 1'b0;
        cen_ch_d  = 1'b0;
`ifdef JT6295_TIMING_SPREAD_EN
        nxt_d  = nxt_q;
        sidx_d = sidx_q;
        done_d = done_q;
        sp     = div_act_q >> CHW;
`endif
        if (cen) begin
            cen_sr_d = (cnt_q == '0);
`ifdef JT6295_TIMING_SPREAD_EN
            // nxt_q walks k*sp; done_q stops it once all CH slots have fired.
            if (!done_q && cnt_q == nxt_q) begin
                cen_ch_d = 1'b1;
                slot_d   = sidx_q;
                nxt_d    = nxt_q + sp;
                sidx_d   = sidx_q + CHW'(1);
                done_d   = (sidx_q == CHW'(CH - 1));
            end
            if (wrap) begin
                nxt_d  = '0;
                sidx_d = '0;
                done_d = 1'b0;
            end
`else
            if (cnt_q < DW'(CH)) begin
                cen_ch_d = 1'b1;
                slot_d   = cnt_q[CHW-1:0];
            end
`endif
            if (wrap) begin
                cnt_d     = '0;
                div_act_d = sel;
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            div_act_q <= sel;
            slot_q    <= '0;
            cen_sr_q  <= 1'b0;
            cen_ch_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            slot_q    <= slot_d;
            cen_sr_q  <= cen_sr_d;
            cen_ch_q  <= cen_ch_d;
        end
    end

`ifdef JT6295_TIMING_SPREAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            nxt_q  <= '0;
            sidx_q <= '0;
            done_q <= 1'b0;
        end else begin
            nxt_q  <= nxt_d;
            sidx_q <= sidx_d;
            done_q <= done_d;
        end
    end
`endif

    assign cen_sr  = cen_sr_q;
    assign cen_ch  = cen_ch_q;
    assign slot    = slot_q;
    assign div_act = div_act_q;

endmodule

// File: tb/tb_jt6295_timing_gen.sv
// Directed self-checking bench for jt6295_timing_gen (CHW=2, DW=10, 132/165 table).
module tb_jt6295_timing_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       ss;
    logic       prog_en;
    logic [9:0] prog_div;
    logic       cen_sr;
    logic       cen_ch;
    logic [1:0] slot;
    logic [9:0] div_act;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jt6295_timing_gen #(
        .CHW    (2),
        .DW     (10),
        .DIV_HI (132),
        .DIV_LO (165)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .ss       (ss),
        .prog_en  (prog_en),
        .prog_div (prog_div),
        .cen_sr   (cen_sr),
        .cen_ch   (cen_ch),
        .slot     (slot),
        .div_act  (div_act)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change at the negedge; outputs are sampled at the following negedge,
    // i.e. half a clock after the posedge that saw this cen value.
    task automatic tick(input logic c);
        cen = c;
        @(negedge clk);
        cen = 1'b0;
    endtask

    // Expected slot strobe for the cen where the counter stood at n.
    task automatic exp_slot(input int n, input int div, output bit hit, output int es);
`ifdef JT6295_TIMING_SPREAD_EN
        int sp;
        sp  = div >> 2;
        hit = (n % sp == 0) && (n / sp < 4);
        es  = n / sp;
`else
        hit = (n < 4);
        es  = n;
`endif
    endtask

    // Drive n_max cens starting at cnt=0 with `gap` idle clocks after each.
    // At cen index chg_at, ss is dropped to 0 (takes effect next period).
    task automatic run_period(input int div, input int gap, input int n_max, input int chg_at);
        bit hit;
        int es;
        for (int n = 0; n < n_max; n++) begin
            if (n == chg_at) ss = 1'b0;
            tick(1'b1);
            exp_slot(n, div, hit, es);
            chk($sformatf("sr d%0d n%0d", div, n), int'(cen_sr), (n == 0) ? 1 : 0);
            chk($sformatf("ch d%0d n%0d", div, n), int'(cen_ch), hit ? 1 : 0);
            if (hit) chk($sformatf("slot d%0d n%0d", div, n), int'(slot), es);
            if (n < div - 1) chk($sformatf("div_act d%0d n%0d", div, n), int'(div_act), div);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0);
                chk($sformatf("sr_idle d%0d n%0d", div, n), int'(cen_sr), 0);
                chk($sformatf("ch_idle d%0d n%0d", div, n), int'(cen_ch), 0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        cen      = 1'b0;
        ss       = 1'b1;
        prog_en  = 1'b0;
        prog_div = '0;
        @(negedge clk);
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        chk("rst cen_sr", int'(cen_sr), 0);
        chk("rst cen_ch", int'(cen_ch), 0);
        chk("rst slot", int'(slot), 0);
        chk("rst div_act", int'(div_act), 132);
        rst = 1'b0;

        // ss=1: two full 132-cen periods at one cen per 4 clk.
        run_period(132, 3, 132, -1);
        // ss drops at cnt=50: this period stays 132, the next is 165.
        run_period(132, 3, 132, 50);
        chk("div_act after ss change", int'(div_act), 165);
        prog_en  = 1'b1;
        prog_div = 10'd3;
        run_period(165, 3, 165, -1);
        chk("div_act clamp 3->8", int'(div_act), 8);
        run_period(8, 3, 8, -1);
        run_period(8, 3, 8, -1);

        // cen held continuously high.
        prog_div = 10'd20;
        run_period(8, 0, 8, -1);
        run_period(20, 0, 20, -1);
        prog_div = 10'd0;
        run_period(20, 0, 20, -1);
        chk("div_act clamp 0->8", int'(div_act), 8);
        prog_div = 10'd8;
        run_period(8, 0, 8, -1);
        prog_en = 1'b0;
        ss      = 1'b1;
        run_period(8, 0, 8, -1);

        // Reset arrives with cen=1 at cnt=70.
        run_period(132, 3, 70, -1);
        rst = 1'b1;
        tick(1'b1);
        chk("midrst cen_sr", int'(cen_sr), 0);
        chk("midrst cen_ch", int'(cen_ch), 0);
        chk("midrst slot", int'(slot), 0);
        chk("midrst div_act", int'(div_act), 132);
        rst = 1'b0;
        tick(1'b0);
        chk("post-rst idle sr", int'(cen_sr), 0);
        run_period(132, 3, 132, -1);
        run_period(132, 3, 4, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

endmodule
